// File: rtl/instr_sequencer_if.sv
// Bus bundle between the instruction sequencer and its memory / execution-unit partners.
// master = sequencer side, slave = memory, decoder and execution-unit side.
interface instr_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             run;
  logic [15:0]      instr_in;
  logic             mem_rdy;
  logic             alu_done;
  logic             mov_done;
  logic             ldsr_done;
  logic             IF;
  logic [15:0]      IR;
  logic [3:0]       opCode;
  logic             ALUstr;
  logic             MOVstr;
  logic             LDSRstr;
  logic             pc_inc;
  logic             halted;
  logic             illegal;
  logic             fault;
  logic [CNT_W-1:0] retired;

  modport master (
    input  run, instr_in, mem_rdy, alu_done, mov_done, ldsr_done,
    output IF, IR, opCode, ALUstr, MOVstr, LDSRstr, pc_inc, halted, illegal, fault, retired
  );

  modport slave (
    output run, instr_in, mem_rdy, alu_done, mov_done, ldsr_done,
    input  IF, IR, opCode, ALUstr, MOVstr, LDSRstr, pc_inc, halted, illegal, fault, retired
  );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction-cycle controller: FETCH -> DECODE -> EXEC -> WAIT -> NEXT for each 16-bit word.
// Optional WAIT timeout with a sticky fault flag is compiled in when SEQ_TIMEOUT_EN is defined.
module instr_sequencer #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned DONE_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  instr_sequencer_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_NEXT   = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [15:0]      ir_q, ir_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [3:0] op;
  logic       is_nop, is_alu, is_mov, is_ldsr, is_halt;
  logic       unit_done;
  logic       timeout_hit;

  assign op      = ir_q[15:12];
  assign is_nop  = (op == 4'd0);
  assign is_alu  = (op != 4'd0) && (op <= 4'd7);
  assign is_mov  = (op == 4'd8);
  assign is_ldsr = (op == 4'd9);
  assign is_halt = (op == 4'd15);

  // Only the done of the unit that was started counts; others are ignored.
  assign unit_done = (is_alu  & bus.alu_done) |
                     (is_mov  & bus.mov_done) |
                     (is_ldsr & bus.ldsr_done);

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: begin
        if (bus.run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (bus.mem_rdy) begin
          ir_d    = bus.instr_in;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_nop) begin
          state_d = S_NEXT;
        end else if (is_alu || is_mov || is_ldsr) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_HALT;
          if (!is_halt) illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (unit_done)        state_d = S_NEXT;
        else if (timeout_hit) state_d = S_HALT;
      end
      S_NEXT: begin
        retired_d = retired_q + CNT_W'(1);
        state_d   = bus.run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  // Counter holds 0..DONE_TIMEOUT-1; it is cleared in EXEC so it reads 0 on the first WAIT cycle.
  localparam int unsigned TO_W = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;

  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            fault_q;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == S_EXEC)      wait_cnt_d = '0;
    else if (state_q == S_WAIT) wait_cnt_d = wait_cnt_q + TO_W'(1);
  end

  assign timeout_hit = (state_q == S_WAIT) && !unit_done &&
                       (wait_cnt_q == TO_W'(DONE_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      if (timeout_hit) fault_q <= 1'b1;
    end
  end

  assign bus.fault = fault_q;
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign unused_timeout = ^DONE_TIMEOUT;
  assign bus.fault      = 1'b0;
`endif

  // Strobes and status decode straight from the registered state, so reset clears them next cycle.
  assign bus.IF      = (state_q == S_FETCH);
  assign bus.IR      = ir_q;
  assign bus.opCode  = op;
  assign bus.ALUstr  = (state_q == S_EXEC) && is_alu;
  assign bus.MOVstr  = (state_q == S_EXEC) && is_mov;
  assign bus.LDSRstr = (state_q == S_EXEC) && is_ldsr;
  assign bus.pc_inc  = (state_q == S_NEXT);
  assign bus.halted  = (state_q == S_HALT);
  assign bus.illegal = illegal_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus randomized instruction streams
// checked against a per-instruction cycle/strobe model.
module tb_instr_sequencer;

  localparam int unsigned TB_TO = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   exp_retired = 0;
  bit   exp_illegal = 1'b0;

  always #5 clk = ~clk;

  instr_sequencer_if #(.CNT_W(16)) bus ();

  instr_sequencer #(
    .CNT_W        (16),
    .DONE_TIMEOUT (TB_TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 0 NOP, 1 ALU, 2 MOV, 3 LDSR, 4 HALT, 5 illegal
  function automatic int op_class(input logic [3:0] op);
    int o;
    o = int'(op);
    if (o == 0)  return 0;
    if (o <= 7)  return 1;
    if (o == 8)  return 2;
    if (o == 9)  return 3;
    if (o == 15) return 4;
    return 5;
  endfunction

  task automatic clear_inputs();
    bus.mem_rdy   = 1'b0;
    bus.alu_done  = 1'b0;
    bus.mov_done  = 1'b0;
    bus.ldsr_done = 1'b0;
  endtask

  task automatic drive_done(input int cls, input bit match);
    if (match) begin
      bus.alu_done  = (cls == 1);
      bus.mov_done  = (cls == 2);
      bus.ldsr_done = (cls == 3);
    end else begin
      bus.alu_done  = (cls != 1);
      bus.mov_done  = (cls != 2);
      bus.ldsr_done = (cls != 3);
    end
  endtask

  task automatic do_reset();
    bus.run  = 1'b0;
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_retired = 0;
    exp_illegal = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_IF"},      bus.IF, 1'b0);
    chk({tag, "_IR"},      bus.IR, 16'h0000);
    chk({tag, "_retired"}, bus.retired, 16'h0000);
    chk({tag, "_halted"},  bus.halted, 1'b0);
    chk({tag, "_illegal"}, bus.illegal, 1'b0);
    chk({tag, "_fault"},   bus.fault, 1'b0);
    chk({tag, "_strobes"}, {bus.ALUstr, bus.MOVstr, bus.LDSRstr, bus.pc_inc}, 4'b0000);
  endtask

  // Plays memory and execution units for one instruction. m = extra fetch cycles before mem_rdy,
  // d = WAIT cycles before the matching done (d<0: never). Returns at the pc_inc or halted cycle.
  task automatic run_instr(input logic [15:0] w, input int m, input int d,
                           input bit stray, input bit stop);
    int  cls, k, cyc, if_n, wait_n, n_alu, n_mov, n_ldsr, n_pc, multi, exp_end;
    bit  exec_seen, fin, is_exec;
    cls     = op_class(w[15:12]);
    is_exec = (cls >= 1) && (cls <= 3);
    k = 0;
    while (bus.IF !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("fetch_req", bus.IF, 1'b1);
    chk("retired_pre", bus.retired, exp_retired & 32'hFFFF);
    cyc = 0; if_n = 0; wait_n = 0; n_alu = 0; n_mov = 0; n_ldsr = 0; n_pc = 0; multi = 0;
    exec_seen = 1'b0; fin = 1'b0;
    while (!fin && cyc < 300) begin
      clear_inputs();
      if ((int'(bus.ALUstr) + int'(bus.MOVstr) + int'(bus.LDSRstr) + int'(bus.pc_inc)) > 1) multi++;
      if (bus.IF) begin
        if_n++;
        bus.instr_in = (if_n > m) ? w : 16'($urandom);
        bus.mem_rdy  = (if_n > m);
      end
      if (bus.ALUstr)  n_alu++;
      if (bus.MOVstr)  n_mov++;
      if (bus.LDSRstr) n_ldsr++;
      if (bus.pc_inc)  n_pc++;
      if (bus.ALUstr || bus.MOVstr || bus.LDSRstr) begin
        exec_seen = 1'b1;
        wait_n    = 0;
        if (stray) drive_done(cls, 1'b1);
      end else if (exec_seen && !bus.pc_inc && !bus.halted) begin
        if (wait_n == d) drive_done(cls, 1'b1);
        else if (stray)  drive_done(cls, 1'b0);
        wait_n++;
      end
      if (bus.pc_inc || bus.halted) begin
        fin = 1'b1;
        if (stop && bus.pc_inc) bus.run = 1'b0;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    clear_inputs();
    chk("instr_end_seen", fin, 1'b1);
    chk("IR", bus.IR, w);
    chk("opCode", bus.opCode, w[15:12]);
    chk("one_hot_strobes", multi, 0);
    chk("fetch_cycles", if_n, m + 1);
    if (cls <= 3 && d >= 0) begin
      exp_end = is_exec ? m + 5 + d : m + 3;
      chk("instr_cycles", cyc + 1, exp_end);
      chk("pc_inc_pulses", n_pc, 1);
      chk("halted", bus.halted, 1'b0);
      chk("ALUstr_pulses",  n_alu,  (cls == 1) ? 1 : 0);
      chk("MOVstr_pulses",  n_mov,  (cls == 2) ? 1 : 0);
      chk("LDSRstr_pulses", n_ldsr, (cls == 3) ? 1 : 0);
      exp_retired++;
    end else if (is_exec) begin
      chk("timeout_cycles", cyc + 1, m + 4 + int'(TB_TO));
      chk("timeout_halted", bus.halted, 1'b1);
      chk("timeout_fault", bus.fault, 1'b1);
      chk("timeout_pc_inc", n_pc, 0);
      chk("timeout_strobe", n_alu + n_mov + n_ldsr, 1);
    end else begin
      if (cls == 5) exp_illegal = 1'b1;
      chk("halt_cycles", cyc + 1, m + 3);
      chk("halt_halted", bus.halted, 1'b1);
      chk("halt_illegal", bus.illegal, exp_illegal);
      chk("halt_pc_inc", n_pc, 0);
      chk("halt_strobes", n_alu + n_mov + n_ldsr, 0);
    end
  endtask

  initial begin
    logic [15:0] w;
    int          dmax;
    int          k;
`ifdef SEQ_TIMEOUT_EN
    dmax = int'(TB_TO) - 1;
`else
    dmax = 6;
`endif
    bus.run      = 1'b0;
    bus.instr_in = '0;
    clear_inputs();
    reset = 1'b0;
    @(negedge clk);

    do_reset();
    chk_reset_state("reset");
    repeat (3) @(negedge clk);
    chk("idle_no_fetch", bus.IF, 1'b0);

    // Best-case ALU (ADDI) instruction
    bus.run = 1'b1;
    run_instr(16'h700A, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("alu_retired", bus.retired, 16'd1);

    // MOV with slow memory, slow done and stray alu_done
    do_reset();
    bus.run = 1'b1;
    run_instr(16'h8041, 3, 4, 1'b1, 1'b0);
    @(negedge clk);
    chk("mov_retired", bus.retired, 16'd1);

    // Randomized stream of non-halting instructions, stopping after the last one
    for (int i = 0; i < 30; i++) begin
      w = {4'($urandom_range(0, 9)), 12'($urandom)};
      run_instr(w, $urandom_range(0, 3), $urandom_range(0, dmax), 1'($urandom), (i == 29));
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stop_idle_IF", bus.IF, 1'b0);
    end
    chk("stream_retired", bus.retired, exp_retired & 32'hFFFF);

    // NOP, LDSR, HALT
    do_reset();
    bus.run = 1'b1;
    run_instr(16'h0000, 0, 0, 1'b0, 1'b0);
    run_instr(16'h9000, $urandom_range(0, 2), $urandom_range(0, dmax), 1'b0, 1'b0);
    run_instr(16'hF000, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("halt_no_fetch", bus.IF, 1'b0);
      chk("halt_stays", bus.halted, 1'b1);
    end
    chk("halt_retired", bus.retired, 16'd2);

    // Illegal opcodes
    do_reset();
    bus.run = 1'b1;
    run_instr(16'hA123, 0, 0, 1'b0, 1'b0);
    chk("illegal_retired", bus.retired, 16'd0);
    do_reset();
    chk_reset_state("post_illegal_reset");
    bus.run = 1'b1;
    w = {4'($urandom_range(10, 14)), 12'($urandom)};
    run_instr(w, $urandom_range(0, 3), 0, 1'b0, 1'b0);

    // Reset while waiting for alu_done, with alu_done on the same edge
    do_reset();
    bus.run      = 1'b1;
    bus.instr_in = 16'h7123;
    k = 0;
    while (bus.ALUstr !== 1'b1 && k < 50) begin
      bus.mem_rdy = bus.IF;
      @(negedge clk);
      k++;
    end
    bus.mem_rdy = 1'b0;
    chk("rst_wait_strobe", bus.ALUstr, 1'b1);
    repeat (2) @(negedge clk);
    reset         = 1'b1;
    bus.alu_done  = 1'b1;
    bus.run       = 1'b0;
    @(negedge clk);
    reset        = 1'b0;
    bus.alu_done = 1'b0;
    chk("rst_wait_pc_inc", bus.pc_inc, 1'b0);
    chk_reset_state("rst_wait");
    @(negedge clk);
    chk("rst_wait_idle", {bus.IF, bus.pc_inc, bus.ALUstr}, 3'b000);

`ifdef SEQ_TIMEOUT_EN
    do_reset();
    bus.run = 1'b1;
    run_instr(16'h7005, 0, int'(TB_TO) - 1, 1'b0, 1'b0);
    chk("late_done_no_fault", bus.fault, 1'b0);
    run_instr(16'h1FFF, $urandom_range(0, 2), -1, 1'b0, 1'b0);
    chk("timeout_retired", bus.retired, 16'd1);
`endif

    do_reset();
    chk_reset_state("final_reset");
    chk("final_fault", bus.fault, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
